// File: rtl/align_pipe.sv
// Two-stage floating-point operand aligner: stage 1 decodes, orders and swaps the pair,
// stage 2 right-shifts the smaller mantissa with sticky and flags exact cancellation.
module align_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int GRD_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     op_sub,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sign_big,
  output logic                     sign_small,
  output logic [MAN_W+GRD_W:0]     man_big,
  output logic [MAN_W+GRD_W:0]     man_small,
  output logic [EXP_W-1:0]         exp_out,
  output logic                     swapped,
  output logic                     eff_sub,
  output logic                     cancel
);

  localparam int AW = MAN_W + 1 + GRD_W;
  localparam logic [31:0] AW_U = 32'(AW);

  logic en;

  logic sa, sb, swap;
  logic [EXP_W-1:0] ea, eb;
  logic [AW-1:0] ma, mb;

  logic s1_valid_q, s1_valid_d;
  logic s1_sign_big_q, s1_sign_big_d;
  logic s1_sign_small_q, s1_sign_small_d;
  logic [EXP_W-1:0] s1_exp_big_q, s1_exp_big_d;
  logic [EXP_W-1:0] s1_exp_small_q, s1_exp_small_d;
  logic [AW-1:0] s1_man_big_q, s1_man_big_d;
  logic [AW-1:0] s1_man_small_q, s1_man_small_d;
  logic s1_swapped_q, s1_swapped_d;

  logic [EXP_W-1:0] shift_d;
  logic [31:0] shift_ext;
  logic [AW-1:0] shifted, lost_mask, aligned;
  logic sticky, is_cancel, is_zero;

  logic out_valid_q, out_valid_d;
  logic sign_big_q, sign_big_d;
  logic sign_small_q, sign_small_d;
  logic [AW-1:0] man_big_q, man_big_d;
  logic [AW-1:0] man_small_q, man_small_d;
  logic [EXP_W-1:0] exp_out_q, exp_out_d;
  logic swapped_q, swapped_d;
  logic eff_sub_q, eff_sub_d;
  logic cancel_q, cancel_d;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // Denormals use effective exponent 1 with a zero hidden bit.
  always_comb begin
    sa   = in_a[EXP_W+MAN_W];
    sb   = in_b[EXP_W+MAN_W] ^ op_sub;
    ea   = (in_a[EXP_W+MAN_W-1:MAN_W] == '0) ? EXP_W'(1) : in_a[EXP_W+MAN_W-1:MAN_W];
    eb   = (in_b[EXP_W+MAN_W-1:MAN_W] == '0) ? EXP_W'(1) : in_b[EXP_W+MAN_W-1:MAN_W];
    ma   = {|in_a[EXP_W+MAN_W-1:MAN_W], in_a[MAN_W-1:0], {GRD_W{1'b0}}};
    mb   = {|in_b[EXP_W+MAN_W-1:MAN_W], in_b[MAN_W-1:0], {GRD_W{1'b0}}};
    swap = (eb > ea) || ((eb == ea) && (mb > ma));
  end

  always_comb begin
    s1_valid_d      = s1_valid_q;
    s1_sign_big_d   = s1_sign_big_q;
    s1_sign_small_d = s1_sign_small_q;
    s1_exp_big_d    = s1_exp_big_q;
    s1_exp_small_d  = s1_exp_small_q;
    s1_man_big_d    = s1_man_big_q;
    s1_man_small_d  = s1_man_small_q;
    s1_swapped_d    = s1_swapped_q;
    if (en) begin
      s1_valid_d      = in_valid;
      s1_swapped_d    = swap;
      s1_sign_big_d   = swap ? sb : sa;
      s1_sign_small_d = swap ? sa : sb;
      s1_exp_big_d    = swap ? eb : ea;
      s1_exp_small_d  = swap ? ea : eb;
      s1_man_big_d    = swap ? mb : ma;
      s1_man_small_d  = swap ? ma : mb;
    end
  end

  // Bits shifted out of the small mantissa fold into its LSB.
  always_comb begin
    shift_d   = s1_exp_big_q - s1_exp_small_q;
    shift_ext = 32'(shift_d);
    shifted   = s1_man_small_q >> shift_d;
    lost_mask = ~({AW{1'b1}} << shift_d);
    sticky    = |(s1_man_small_q & lost_mask);
    if (shift_ext >= AW_U) aligned = {{(AW-1){1'b0}}, |s1_man_small_q};
    else                   aligned = {shifted[AW-1:1], shifted[0] | sticky};
    is_zero   = (s1_man_big_q == '0);
    is_cancel = (s1_sign_big_q != s1_sign_small_q) && (shift_d == '0) &&
                (s1_man_big_q == s1_man_small_q);
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    sign_big_d   = sign_big_q;
    sign_small_d = sign_small_q;
    man_big_d    = man_big_q;
    man_small_d  = man_small_q;
    exp_out_d    = exp_out_q;
    swapped_d    = swapped_q;
    eff_sub_d    = eff_sub_q;
    cancel_d     = cancel_q;
    if (en) begin
      out_valid_d  = s1_valid_q;
      sign_big_d   = s1_sign_big_q;
      sign_small_d = s1_sign_small_q;
      man_big_d    = s1_man_big_q;
      man_small_d  = aligned;
      exp_out_d    = (is_zero || is_cancel) ? '0 : s1_exp_big_q;
      swapped_d    = s1_swapped_q;
      eff_sub_d    = s1_sign_big_q != s1_sign_small_q;
      cancel_d     = is_cancel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q      <= 1'b0;
      s1_sign_big_q   <= 1'b0;
      s1_sign_small_q <= 1'b0;
      s1_exp_big_q    <= '0;
      s1_exp_small_q  <= '0;
      s1_man_big_q    <= '0;
      s1_man_small_q  <= '0;
      s1_swapped_q    <= 1'b0;
      out_valid_q     <= 1'b0;
      sign_big_q      <= 1'b0;
      sign_small_q    <= 1'b0;
      man_big_q       <= '0;
      man_small_q     <= '0;
      exp_out_q       <= '0;
      swapped_q       <= 1'b0;
      eff_sub_q       <= 1'b0;
      cancel_q        <= 1'b0;
    end else begin
      s1_valid_q      <= s1_valid_d;
      s1_sign_big_q   <= s1_sign_big_d;
      s1_sign_small_q <= s1_sign_small_d;
      s1_exp_big_q    <= s1_exp_big_d;
      s1_exp_small_q  <= s1_exp_small_d;
      s1_man_big_q    <= s1_man_big_d;
      s1_man_small_q  <= s1_man_small_d;
      s1_swapped_q    <= s1_swapped_d;
      out_valid_q     <= out_valid_d;
      sign_big_q      <= sign_big_d;
      sign_small_q    <= sign_small_d;
      man_big_q       <= man_big_d;
      man_small_q     <= man_small_d;
      exp_out_q       <= exp_out_d;
      swapped_q       <= swapped_d;
      eff_sub_q       <= eff_sub_d;
      cancel_q        <= cancel_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign sign_big   = sign_big_q;
  assign sign_small = sign_small_q;
  assign man_big    = man_big_q;
  assign man_small  = man_small_q;
  assign exp_out    = exp_out_q;
  assign swapped    = swapped_q;
  assign eff_sub    = eff_sub_q;
  assign cancel     = cancel_q;

endmodule

// File: tb/tb_align_pipe.sv
// Directed bench for align_pipe: hand-computed result vectors, latency, stall and reset behaviour.
module tb_align_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic op_sub = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic sign_big, sign_small, swapped, eff_sub, cancel;
  logic [13:0] man_big, man_small;
  logic [4:0] exp_out;
  logic [37:0] obs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  align_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .sign_big(sign_big), .sign_small(sign_small),
    .man_big(man_big), .man_small(man_small), .exp_out(exp_out),
    .swapped(swapped), .eff_sub(eff_sub), .cancel(cancel)
  );

  // {sign_big, sign_small, swapped, eff_sub, cancel, exp_out, man_big, man_small}
  assign obs = {sign_big, sign_small, swapped, eff_sub, cancel, exp_out, man_big, man_small};

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [37:0] want;
  } vec_t;

  vec_t vt[12];

  function automatic logic [37:0] ev(input logic sbig, input logic ssml, input logic sw,
                                     input logic es, input logic ca, input logic [4:0] eo,
                                     input logic [13:0] mb, input logic [13:0] ms);
    return {sbig, ssml, sw, es, ca, eo, mb, ms};
  endfunction

  function automatic void load_vectors();
    vt[0]  = '{1'b0, 16'h3C00, 16'h3800, ev(0, 0, 0, 0, 0, 5'd15, 14'h2000, 14'h1000)};
    vt[1]  = '{1'b0, 16'h3800, 16'hBC00, ev(1, 0, 1, 1, 0, 5'd15, 14'h2000, 14'h1000)};
    vt[2]  = '{1'b1, 16'h3C00, 16'h3C00, ev(0, 1, 0, 1, 1, 5'd0,  14'h2000, 14'h2000)};
    vt[3]  = '{1'b0, 16'h7800, 16'h0401, ev(0, 0, 0, 0, 0, 5'd30, 14'h2000, 14'h0001)};
    vt[4]  = '{1'b0, 16'h0000, 16'h0000, ev(0, 0, 0, 0, 0, 5'd0,  14'h0000, 14'h0000)};
    vt[5]  = '{1'b0, 16'h4000, 16'h3001, ev(0, 0, 0, 0, 0, 5'd16, 14'h2000, 14'h0201)};
    vt[6]  = '{1'b0, 16'h0001, 16'h0002, ev(0, 0, 1, 0, 0, 5'd1,  14'h0010, 14'h0008)};
    vt[7]  = '{1'b0, 16'h3C00, 16'h3C01, ev(0, 0, 1, 0, 0, 5'd15, 14'h2008, 14'h2000)};
    vt[8]  = '{1'b1, 16'h3C00, 16'h3800, ev(0, 1, 0, 1, 0, 5'd15, 14'h2000, 14'h1000)};
    vt[9]  = '{1'b0, 16'hBC00, 16'hBC00, ev(1, 1, 0, 0, 0, 5'd15, 14'h2000, 14'h2000)};
    vt[10] = '{1'b1, 16'h0000, 16'h0000, ev(0, 1, 0, 1, 1, 5'd0,  14'h0000, 14'h0000)};
    vt[11] = '{1'b0, 16'h3800, 16'h0801, ev(0, 0, 0, 0, 0, 5'd14, 14'h2000, 14'h0003)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++;
    if (obs !== 38'h0) begin errors++; $display("FAIL reset_outputs: got %h want 0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      op_sub = vt[i].op;
      in_a = vt[i].a;
      in_b = vt[i].b;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL vec%0d_in_ready: got %b want 1", i, in_ready); end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_early_valid: got %b want 0", i, out_valid); end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL vec%0d_out_valid: got %b want 1", i, out_valid); end
      checks++;
      if (obs !== vt[i].want) begin errors++; $display("FAIL vec%0d_data: got %h want %h", i, obs, vt[i].want); end
    end
  endtask

  task automatic test_back_to_back();
    int sidx[5] = '{0, 1, 2, 5, 7};
    int sent = 0;
    int got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(posedge clk);
      #1;
      out_ready = !(c >= 2 && c <= 4);
      if (sent < 5) begin
        in_valid = 1'b1;
        op_sub = vt[sidx[sent]].op;
        in_a = vt[sidx[sent]].a;
        in_b = vt[sidx[sent]].b;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready c%0d: got %b want 0", c, in_ready); end
        checks++;
        if (obs !== vt[sidx[got]].want) begin errors++; $display("FAIL b2b_hold c%0d: got %h want %h", c, obs, vt[sidx[got]].want); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (obs !== vt[sidx[got]].want) begin errors++; $display("FAIL b2b_result%0d: got %h want %h", got, obs, vt[sidx[got]].want); end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got !== 5) begin errors++; $display("FAIL b2b_count: got %0d want 5", got); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      op_sub = vt[i].op;
      in_a = vt[i].a;
      in_b = vt[i].b;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    checks++;
    if (obs !== 38'h0) begin errors++; $display("FAIL midrst_outputs: got %h want 0", obs); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale c%0d: got %b want 0", c, out_valid); end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    op_sub = vt[5].op;
    in_a = vt[5].a;
    in_b = vt[5].b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_early_valid: got %b want 0", out_valid); end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_out_valid_after: got %b want 1", out_valid); end
    checks++;
    if (obs !== vt[5].want) begin errors++; $display("FAIL midrst_data: got %h want %h", obs, vt[5].want); end
  endtask

  initial begin
    load_vectors();
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
